// File: rtl/vc_skid_buffer_pkg.sv
// Shared definitions for vc_skid_buffer: state encoding and occupancy width.
// The state encoding doubles as the occupancy count.
package vc_skid_buffer_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    // Bits needed to hold a count in 0..max_count.
    function automatic int unsigned count_width(input int unsigned max_count);
        return $clog2(max_count + 1);
    endfunction

    localparam int unsigned NUM_ENTRIES_W = count_width(SKID_DEPTH);

    typedef enum logic [NUM_ENTRIES_W-1:0] {
        STATE_EMPTY = 2'd0,
        STATE_ONE   = 2'd1,
        STATE_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/vc_skid_buffer_ctrl.sv
// Skid buffer control: occupancy state machine and data-register enables.
// enq_rdy depends on state and reset only, never on deq_rdy.
module vc_skid_buffer_ctrl
    import vc_skid_buffer_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_val,
    input  logic                     deq_rdy,
    output logic                     enq_rdy,
    output logic                     deq_val,
    output logic [NUM_ENTRIES_W-1:0] num_entries,
    output logic                     main_en,
    output logic                     main_sel_skid,
    output logic                     skid_en
);

    state_t state;
    state_t state_next;
    logic   enq_fire;
    logic   deq_fire;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= STATE_EMPTY;
        else       state <= state_next;
    end

    assign num_entries = state;
    assign deq_val     = (state != STATE_EMPTY);
    assign enq_rdy     = (state != STATE_TWO) && !reset;
    assign enq_fire    = enq_val && enq_rdy;
    assign deq_fire    = deq_val && deq_rdy;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        main_en       = 1'b0;
        main_sel_skid = 1'b0;
        skid_en       = 1'b0;
        unique case (state)
            STATE_EMPTY: begin
                if (enq_fire) begin
                    main_en    = 1'b1;
                    state_next = STATE_ONE;
                end
            end
            STATE_ONE: begin
                if (enq_fire && deq_fire) begin
                    main_en = 1'b1;
                end else if (enq_fire) begin
                    skid_en    = 1'b1;
                    state_next = STATE_TWO;
                end else if (deq_fire) begin
                    state_next = STATE_EMPTY;
                end
            end
            STATE_TWO: begin
                if (deq_fire) begin
                    main_en       = 1'b1;
                    main_sel_skid = 1'b1;
                    state_next    = STATE_ONE;
                end
            end
            default: state_next = STATE_EMPTY;
        endcase
    end

endmodule

// File: rtl/vc_skid_buffer.sv
// Two-entry val/rdy skid buffer with a fully registered enq_rdy.
// Optional protocol checks are compiled in with VC_SKID_BUFFER_ASSERT_EN.
module vc_skid_buffer
    import vc_skid_buffer_pkg::*;
#(
    parameter int unsigned          p_nbits       = 32,
    parameter logic [p_nbits-1:0]   p_reset_value = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg,
    output logic [1:0]         num_entries
);

    logic               main_en;
    logic               main_sel_skid;
    logic               skid_en;
    logic [p_nbits-1:0] main_q;
    logic [p_nbits-1:0] skid_q;

    vc_skid_buffer_ctrl u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .enq_val       (enq_val),
        .deq_rdy       (deq_rdy),
        .enq_rdy       (enq_rdy),
        .deq_val       (deq_val),
        .num_entries   (num_entries),
        .main_en       (main_en),
        .main_sel_skid (main_sel_skid),
        .skid_en       (skid_en)
    );

    // NOTE: the data registers are reset on purpose so deq_msg shows a known
    // value after reset; payload storage is otherwise usually left unreset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= p_reset_value;
            skid_q <= p_reset_value;
        end else begin
            if (main_en) main_q <= main_sel_skid ? skid_q : enq_msg;
            if (skid_en) skid_q <= enq_msg;
        end
    end

    assign deq_msg = main_q;

`ifdef VC_SKID_BUFFER_ASSERT_EN
`ifndef VC_ASSERT_NOT_X
`define VC_ASSERT_NOT_X(sig) assert (!$isunknown(sig)) else $fatal(1, "VC_ASSERT_NOT_X: input is unknown")
`endif

    logic               prev_blocked;
    logic [p_nbits-1:0] prev_msg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_blocked <= 1'b0;
            prev_msg     <= p_reset_value;
        end else begin
            prev_blocked <= enq_val && !enq_rdy;
            prev_msg     <= enq_msg;
        end
    end

    // A producer held off by enq_rdy=0 must keep offering the same message.
    always @(posedge clk) begin
        if (!reset) begin
            `VC_ASSERT_NOT_X(enq_val);
            `VC_ASSERT_NOT_X(deq_rdy);
            assert (num_entries != 2'd3)
                else $fatal(1, "vc_skid_buffer: occupancy reached 3");
            if (prev_blocked) begin
                assert (enq_val && (enq_msg == prev_msg))
                    else $fatal(1, "vc_skid_buffer: producer dropped or changed a stalled message");
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_skid_buffer.sv
// Self-checking bench for vc_skid_buffer: directed scenarios plus a random
// val/rdy run, all deliveries checked against a reference queue.
module tb_vc_skid_buffer;

    localparam int unsigned    NB = 8;
    localparam logic [NB-1:0]  RV = 8'h5C;

    logic          clk = 1'b0;
    logic          reset;
    logic          enq_val;
    logic          enq_rdy;
    logic [NB-1:0] enq_msg;
    logic          deq_val;
    logic          deq_rdy;
    logic [NB-1:0] deq_msg;
    logic [1:0]    num_entries;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [NB-1:0] sb[$];

    vc_skid_buffer #(.p_nbits(NB), .p_reset_value(RV)) dut (
        .clk         (clk),
        .reset       (reset),
        .enq_val     (enq_val),
        .enq_rdy     (enq_rdy),
        .enq_msg     (enq_msg),
        .deq_val     (deq_val),
        .deq_rdy     (deq_rdy),
        .deq_msg     (deq_msg),
        .num_entries (num_entries)
    );

    always #5 clk = ~clk;

    // Records the handshakes of the current cycle into the scoreboard, then
    // advances to 1 time unit after the next rising edge.
    task automatic tick(output bit dfire, output logic [NB-1:0] got,
                        output logic [NB-1:0] exp, output bit sb_empty);
        dfire    = deq_val && deq_rdy;
        got      = deq_msg;
        exp      = '0;
        sb_empty = 1'b0;
        if (dfire) begin
            if (sb.size() == 0) sb_empty = 1'b1;
            else                exp = sb.pop_front();
        end
        if (enq_val && enq_rdy) sb.push_back(enq_msg);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit dfire, sbe;
        logic [NB-1:0] got, exp;
        reset = 1'b1; enq_val = 1'b0; deq_rdy = 1'b0; enq_msg = '0;
        #2;
        n_checks++; if (deq_val !== 1'b0) $display("FAIL reset_deq_val got %b exp 0", deq_val); else n_pass++;
        n_checks++; if (enq_rdy !== 1'b0) $display("FAIL reset_enq_rdy got %b exp 0", enq_rdy); else n_pass++;
        n_checks++; if (num_entries !== 2'd0) $display("FAIL reset_num_entries got %0d exp 0", num_entries); else n_pass++;
        n_checks++; if (deq_msg !== RV) $display("FAIL reset_deq_msg got %h exp %h", deq_msg, RV); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        tick(dfire, got, exp, sbe);
        n_checks++; if (enq_rdy !== 1'b1) $display("FAIL release_enq_rdy got %b exp 1", enq_rdy); else n_pass++;
        n_checks++; if (deq_val !== 1'b0) $display("FAIL release_deq_val got %b exp 0", deq_val); else n_pass++;
        n_checks++; if (deq_msg !== RV) $display("FAIL release_deq_msg got %h exp %h", deq_msg, RV); else n_pass++;
    endtask

    task automatic test_single();
        bit dfire, sbe;
        logic [NB-1:0] got, exp;
        enq_val = 1'b1; enq_msg = 8'hA5; deq_rdy = 1'b1;
        tick(dfire, got, exp, sbe);
        enq_val = 1'b0;
        n_checks++; if (deq_val !== 1'b1) $display("FAIL single_deq_val got %b exp 1", deq_val); else n_pass++;
        n_checks++; if (deq_msg !== 8'hA5) $display("FAIL single_deq_msg got %h exp a5", deq_msg); else n_pass++;
        n_checks++; if (num_entries !== 2'd1) $display("FAIL single_num_entries got %0d exp 1", num_entries); else n_pass++;
        tick(dfire, got, exp, sbe);
        n_checks++; if (!dfire || sbe || got !== exp) $display("FAIL single_deq fire %b got %h exp %h", dfire, got, exp); else n_pass++;
        n_checks++; if (deq_val !== 1'b0 || num_entries !== 2'd0)
            $display("FAIL single_empty got val %b n %0d exp val 0 n 0", deq_val, num_entries); else n_pass++;
    endtask

    task automatic test_throughput();
        bit dfire, sbe;
        logic [NB-1:0] got, exp;
        int fires = 0;
        enq_val = 1'b1; deq_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            enq_msg = NB'(i);
            tick(dfire, got, exp, sbe);
            if (i > 1) begin
                n_checks++; if (!dfire || sbe || got !== exp)
                    $display("FAIL stream_deq cycle %0d fire %b got %h exp %h", i, dfire, got, exp); else n_pass++;
            end
            if (dfire) fires++;
            n_checks++; if (num_entries !== 2'd1) $display("FAIL stream_num_entries cycle %0d got %0d exp 1", i, num_entries); else n_pass++;
        end
        enq_val = 1'b0;
        tick(dfire, got, exp, sbe);
        if (dfire && !sbe && got === exp) fires++;
        n_checks++; if (fires != 16 || got !== 8'h10) $display("FAIL stream_total got %0d last %h exp 16 last 10", fires, got); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit dfire, sbe;
        logic [NB-1:0] got, exp;
        deq_rdy = 1'b0; enq_val = 1'b1;
        enq_msg = 8'h11; tick(dfire, got, exp, sbe);
        enq_msg = 8'h22; tick(dfire, got, exp, sbe);
        enq_val = 1'b0;
        n_checks++; if (num_entries !== 2'd2) $display("FAIL bp_num_entries got %0d exp 2", num_entries); else n_pass++;
        n_checks++; if (enq_rdy !== 1'b0) $display("FAIL bp_enq_rdy got %b exp 0", enq_rdy); else n_pass++;
        tick(dfire, got, exp, sbe);
        n_checks++; if (deq_val !== 1'b1 || deq_msg !== 8'h11)
            $display("FAIL bp_hold got val %b msg %h exp val 1 msg 11", deq_val, deq_msg); else n_pass++;
        deq_rdy = 1'b1;
        tick(dfire, got, exp, sbe);
        n_checks++; if (!dfire || sbe || got !== 8'h11 || exp !== 8'h11) $display("FAIL bp_first got %h exp 11", got); else n_pass++;
        n_checks++; if (enq_rdy !== 1'b1 || num_entries !== 2'd1)
            $display("FAIL bp_after_first got rdy %b n %0d exp rdy 1 n 1", enq_rdy, num_entries); else n_pass++;
        tick(dfire, got, exp, sbe);
        n_checks++; if (!dfire || sbe || got !== 8'h22 || exp !== 8'h22) $display("FAIL bp_second got %h exp 22", got); else n_pass++;
        // Refill to two entries, then reset mid-operation.
        deq_rdy = 1'b0; enq_val = 1'b1;
        enq_msg = 8'h33; tick(dfire, got, exp, sbe);
        enq_msg = 8'h44; tick(dfire, got, exp, sbe);
        enq_val = 1'b0;
        n_checks++; if (num_entries !== 2'd2) $display("FAIL refill_num_entries got %0d exp 2", num_entries); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (deq_val !== 1'b0 || enq_rdy !== 1'b0 || num_entries !== 2'd0)
            $display("FAIL midreset got val %b rdy %b n %0d exp 0 0 0", deq_val, enq_rdy, num_entries); else n_pass++;
        n_checks++; if (deq_msg !== RV) $display("FAIL midreset_msg got %h exp %h", deq_msg, RV); else n_pass++;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        tick(dfire, got, exp, sbe);
        n_checks++; if (enq_rdy !== 1'b1 || deq_val !== 1'b0 || deq_msg !== RV)
            $display("FAIL midreset_release got rdy %b val %b msg %h exp 1 0 %h", enq_rdy, deq_val, deq_msg, RV); else n_pass++;
    endtask

    task automatic test_random();
        bit dfire, sbe;
        logic [NB-1:0] got, exp;
        int sent = 0, recv = 0, cycles = 0;
        bit hold = 1'b0;
        logic rdy_before;
        while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
            if (!hold) begin
                enq_val = (sent < 1000) && ($urandom_range(0, 1) == 1);
                enq_msg = NB'($urandom);
            end
            deq_rdy = ($urandom_range(0, 9) < 3);
            rdy_before = enq_rdy;
            deq_rdy = ~deq_rdy;
            #1;
            n_checks++; if (enq_rdy !== rdy_before) $display("FAIL rand_rdy_path cycle %0d got %b exp %b", cycles, enq_rdy, rdy_before); else n_pass++;
            deq_rdy = ~deq_rdy;
            #1;
            n_checks++; if (num_entries !== 2'(sb.size()) || enq_rdy !== (sb.size() < 2) || deq_val !== (sb.size() != 0))
                $display("FAIL rand_state cycle %0d got n %0d rdy %b val %b exp n %0d", cycles, num_entries, enq_rdy, deq_val, sb.size()); else n_pass++;
            hold = enq_val && !enq_rdy;
            if (enq_val && enq_rdy) sent++;
            tick(dfire, got, exp, sbe);
            if (dfire) begin
                recv++;
                n_checks++; if (sbe || got !== exp) $display("FAIL rand_deq cycle %0d got %h exp %h", cycles, got, exp); else n_pass++;
            end
            cycles++;
        end
        enq_val = 1'b0; deq_rdy = 1'b0;
        n_checks++; if (sent != 1000 || recv != 1000) $display("FAIL rand_total got sent %0d recv %0d exp 1000 1000", sent, recv); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_throughput();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vc_skid_buffer.md
Name: vc_skid_buffer

Overview:
- Val/rdy consumer-side storage element. It is the handshaked counterpart of the plain enable registers: the producer writes only when the buffer can accept, and the consumer drains the data.
- Two-entry skid buffer (main + skid slot) that fully registers `enq_rdy`, breaking the combinational ready path between pipeline stages at full throughput.
- Sits between any two val/rdy pipeline stages in the component library.

Parameters:
- p_nbits, 32, message width in bits
- p_reset_value, 0, value loaded into both data registers on reset

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- enq_val  input  1  producer has valid message
- enq_rdy  output  1  buffer can accept; driven from state only, no path from deq_rdy
- enq_msg  input  p_nbits  incoming message
- deq_val  output  1  buffer holds a valid message
- deq_rdy  input  1  consumer accepts message
- deq_msg  output  p_nbits  outgoing message, always the main register
- num_entries  output  2  current occupancy, 0..2

Behaviour:
- Handshake
  - enq fires when enq_val && enq_rdy.
  - deq fires when deq_val && deq_rdy.
  - A message is transferred exactly once per fire.
- State: EMPTY (0 entries), ONE (main full), TWO (main+skid full). State is encoded so that num_entries is a direct register read.
- Outputs
  - deq_val = (state != EMPTY)
  - enq_rdy = (state != TWO) && !reset
  - deq_msg = main
- Transitions, evaluated at posedge:
  - EMPTY, enq: main<=enq_msg, ->ONE. No enq: stay.
  - ONE, enq && deq: main<=enq_msg, stay ONE.
  - ONE, enq only: skid<=enq_msg, ->TWO.
  - ONE, deq only: ->EMPTY; main retains its value.
  - ONE, neither: stay.
  - TWO, deq: main<=skid, ->ONE. TWO never sees enq fire because enq_rdy=0.
  - TWO, no deq: hold.
- Latency and ordering
  - Minimum latency is 1 cycle from enq fire to deq_val; there is no combinational enq->deq bypass.
  - Throughput is 1 msg/cycle in steady state.
  - Strict FIFO order.
- Stability: while deq_val && !deq_rdy, deq_msg and deq_val hold constant.
- Reset
  - Asynchronous assert: state->EMPTY, main/skid->p_reset_value immediately.
  - Outputs during reset: deq_val=0, enq_rdy=0, num_entries=0.
  - Release is synchronous to the next posedge. enq_rdy=1 in the first cycle after deassert.
  - Reset mid-operation discards buffered messages; no deq fires during reset.
- Undefined input: enq_msg is don't-care when enq_val=0.

Optional Feature:
- Macro: VC_SKID_BUFFER_ASSERT_EN
- When defined, on every posedge with !reset the block checks:
  - VC_ASSERT_NOT_X on enq_val and deq_rdy.
  - Internal invariant: num_entries never equals 3.
  - Producer protocol: if enq_val && !enq_rdy in a cycle, then enq_val remains 1 and enq_msg is unchanged in the next cycle.
  - Any failure uses the standard assertion macro, which reports and stops simulation.
- When undefined, none of this logic is compiled and behaviour is otherwise identical.

Decomposition:
- Shared package vc_skid_buffer_pkg holds:
  - state encoding constants: STATE_EMPTY=2'd0, STATE_ONE=2'd1, STATE_TWO=2'd2
  - a width helper for num_entries
- One natural sub-module: vc_skid_buffer_ctrl, containing the state register, next-state logic and data-register enables (main_en, main_sel_skid, skid_en). The top level holds the two data registers and the output muxing.

Test Plan:
- Reset then idle:
  - Assert reset mid-sim with state TWO -> immediately deq_val=0, num_entries=0, enq_rdy=0.
  - Release reset -> next cycle enq_rdy=1, deq_msg=p_reset_value.
- Single pass: enq 0xA5 with deq_rdy=1 -> deq_val=1 and deq_msg=0xA5 one cycle later, deq fires, state returns to EMPTY.
- Full throughput: stream 0x01..0x10 with enq_val=deq_rdy=1 -> 16 messages out in order on 16 consecutive cycles after 1-cycle latency; num_entries stays 1.
- Backpressure skid:
  - Enq 0x11, 0x22 with deq_rdy=0 -> num_entries=2, enq_rdy=0 in the next cycle, deq_msg=0x11 held.
  - Raise deq_rdy -> 0x11 then 0x22 in order, enq_rdy=1 after first deq.
- Random val/rdy: 1000 random messages with 50% enq_val and 30% deq_rdy against a reference queue model -> identical order, no loss or duplication; enq_rdy never depends on same-cycle deq_rdy.
- Assertion build: with VC_SKID_BUFFER_ASSERT_EN, drive enq_val=X after reset -> assertion fires. Without the macro, the same stimulus produces no assertion.
